// File: rtl/psr_cond_unit.sv
// Program status unit: holds CPSR and one SPSR, evaluates condition codes
// against the registered flags, and services MSR/MRS and exception entry/return.
module psr_cond_unit #(
  parameter logic [4:0] RESET_MODE = 5'b10011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exec_valid,
  input  logic [3:0]  cond,
  input  logic        s_bit,
  input  logic [3:0]  alu_nzcv,
  output logic        cond_pass,
  output logic        CF,
  output logic        VF,
  input  logic        msr_we,
  input  logic        msr_spsr,
  input  logic [3:0]  msr_mask,
  input  logic [31:0] msr_data,
  input  logic        mrs_spsr,
  output logic [31:0] psr_rdata,
  input  logic        exc_entry,
  input  logic [4:0]  exc_mode,
  input  logic        exc_return,
  output logic [31:0] cpsr
);

  localparam logic [4:0] MODE_USR = 5'b10000;

  function automatic logic mode_valid(input logic [4:0] m);
    case (m)
      5'b10000, 5'b10001, 5'b10010, 5'b10011,
      5'b10111, 5'b11011, 5'b11111: mode_valid = 1'b1;
      default:                      mode_valid = 1'b0;
    endcase
  endfunction

  logic [3:0] cpsr_nzcv_q, cpsr_nzcv_d;
  logic       cpsr_i_q, cpsr_i_d;
  logic       cpsr_f_q, cpsr_f_d;
  logic [4:0] cpsr_m_q, cpsr_m_d;
  logic [3:0] spsr_nzcv_q, spsr_nzcv_d;
  logic       spsr_i_q, spsr_i_d;
  logic       spsr_f_q, spsr_f_d;
  logic [4:0] spsr_m_q, spsr_m_d;

  logic [31:0] spsr_w;
  logic        flag_upd;
  logic        n_f, z_f, c_f, v_f;

  // Unimplemented mask fields and reserved data bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{msr_mask[2:1], msr_data[27:8], msr_data[5]};

  assign cpsr   = {cpsr_nzcv_q, 20'b0, cpsr_i_q, cpsr_f_q, 1'b0, cpsr_m_q};
  assign spsr_w = {spsr_nzcv_q, 20'b0, spsr_i_q, spsr_f_q, 1'b0, spsr_m_q};

  assign psr_rdata = mrs_spsr ? spsr_w : cpsr;
  assign {n_f, z_f, c_f, v_f} = cpsr_nzcv_q;
  assign CF = c_f;
  assign VF = v_f;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign flag_upd = exec_valid & cond_pass & s_bit;

  // CPSR writers are mutually exclusive by priority; SPSR is owned by
  // exc_entry whenever it fires, otherwise an MSR to SPSR may write it.
  always_comb begin
    cpsr_nzcv_d = cpsr_nzcv_q;
    cpsr_i_d    = cpsr_i_q;
    cpsr_f_d    = cpsr_f_q;
    cpsr_m_d    = cpsr_m_q;
    spsr_nzcv_d = spsr_nzcv_q;
    spsr_i_d    = spsr_i_q;
    spsr_f_d    = spsr_f_q;
    spsr_m_d    = spsr_m_q;

    if (exc_entry) begin
      spsr_nzcv_d = cpsr_nzcv_q;
      spsr_i_d    = cpsr_i_q;
      spsr_f_d    = cpsr_f_q;
      spsr_m_d    = cpsr_m_q;
      cpsr_m_d    = exc_mode;
      cpsr_i_d    = 1'b1;
    end else begin
      if (msr_we && msr_spsr) begin
        if (msr_mask[3]) spsr_nzcv_d = msr_data[31:28];
        if (msr_mask[0]) begin
          spsr_i_d = msr_data[7];
          spsr_f_d = msr_data[6];
          if (mode_valid(msr_data[4:0])) spsr_m_d = msr_data[4:0];
        end
      end

      if (exc_return) begin
        cpsr_nzcv_d = spsr_nzcv_q;
        cpsr_i_d    = spsr_i_q;
        cpsr_f_d    = spsr_f_q;
        cpsr_m_d    = spsr_m_q;
      end else if (msr_we && !msr_spsr) begin
        if (msr_mask[3]) cpsr_nzcv_d = msr_data[31:28];
        if (msr_mask[0] && (cpsr_m_q != MODE_USR)) begin
          cpsr_i_d = msr_data[7];
          cpsr_f_d = msr_data[6];
          if (mode_valid(msr_data[4:0])) cpsr_m_d = msr_data[4:0];
        end
      end else if (flag_upd) begin
        cpsr_nzcv_d = alu_nzcv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr_nzcv_q <= 4'b0;
      cpsr_i_q    <= 1'b1;
      cpsr_f_q    <= 1'b1;
      cpsr_m_q    <= RESET_MODE;
      spsr_nzcv_q <= 4'b0;
      spsr_i_q    <= 1'b0;
      spsr_f_q    <= 1'b0;
      spsr_m_q    <= 5'b0;
    end else begin
      cpsr_nzcv_q <= cpsr_nzcv_d;
      cpsr_i_q    <= cpsr_i_d;
      cpsr_f_q    <= cpsr_f_d;
      cpsr_m_q    <= cpsr_m_d;
      spsr_nzcv_q <= spsr_nzcv_d;
      spsr_i_q    <= spsr_i_d;
      spsr_f_q    <= spsr_f_d;
      spsr_m_q    <= spsr_m_d;
    end
  end

endmodule

// File: tb/tb_psr_cond_unit.sv
// Directed bench for psr_cond_unit: reset, condition sweep, flag gating,
// user-mode protection, exception round trip and strobe priority.
module tb_psr_cond_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec_valid;
  logic [3:0]  cond;
  logic        s_bit;
  logic [3:0]  alu_nzcv;
  logic        cond_pass;
  logic        CF;
  logic        VF;
  logic        msr_we;
  logic        msr_spsr;
  logic [3:0]  msr_mask;
  logic [31:0] msr_data;
  logic        mrs_spsr;
  logic [31:0] psr_rdata;
  logic        exc_entry;
  logic [4:0]  exc_mode;
  logic        exc_return;
  logic [31:0] cpsr;

  int checks = 0;
  int errors = 0;

  psr_cond_unit #(.RESET_MODE(5'b10011)) dut (
    .clk(clk), .rst_n(rst_n), .exec_valid(exec_valid), .cond(cond), .s_bit(s_bit),
    .alu_nzcv(alu_nzcv), .cond_pass(cond_pass), .CF(CF), .VF(VF), .msr_we(msr_we),
    .msr_spsr(msr_spsr), .msr_mask(msr_mask), .msr_data(msr_data), .mrs_spsr(mrs_spsr),
    .psr_rdata(psr_rdata), .exc_entry(exc_entry), .exc_mode(exc_mode),
    .exc_return(exc_return), .cpsr(cpsr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exec_valid = 1'b0; cond = 4'he; s_bit = 1'b0; alu_nzcv = 4'h0;
    msr_we = 1'b0; msr_spsr = 1'b0; msr_mask = 4'h0; msr_data = 32'h0;
    exc_entry = 1'b0; exc_mode = 5'h0; exc_return = 1'b0;
  endtask

  task automatic do_msr(input logic to_spsr, input logic [3:0] mask, input logic [31:0] data);
    msr_we = 1'b1; msr_spsr = to_spsr; msr_mask = mask; msr_data = data;
    tick();
    idle();
  endtask

  // Condition truth written straight from the ARM condition table.
  function automatic logic exp_pass(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cc;         4'h3: return !cc;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cc && !z;   4'h9: return !cc || z;
      4'ha: return n == v;     4'hb: return n != v;
      4'hc: return !z && (n == v);
      4'hd: return z || (n != v);
      4'he: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    idle();
    mrs_spsr = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (cpsr !== 32'h000000D3) begin
      errors++; $display("FAIL reset_cpsr got %h exp %h", cpsr, 32'h000000D3);
    end
    checks++;
    if (psr_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_spsr got %h exp %h", psr_rdata, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    mrs_spsr = 1'b0;
    tick();
    checks++;
    if (psr_rdata !== 32'h000000D3) begin
      errors++; $display("FAIL reset_mrs_cpsr got %h exp %h", psr_rdata, 32'h000000D3);
    end
  endtask

  task automatic test_cond_sweep();
    for (int n = 0; n < 16; n++) begin
      logic [3:0] f;
      f = n[3:0];
      do_msr(1'b0, 4'b1000, {f, 28'h0});
      checks++;
      if (cpsr !== {f, 20'h0, 8'hD3}) begin
        errors++; $display("FAIL sweep_cpsr nzcv=%b got %h exp %h", f, cpsr, {f, 20'h0, 8'hD3});
      end
      for (int c = 0; c < 16; c++) begin
        cond = c[3:0];
        #1;
        checks++;
        if (cond_pass !== exp_pass(f, c[3:0])) begin
          errors++;
          $display("FAIL sweep_cond nzcv=%b cond=%h got %b exp %b", f, c[3:0], cond_pass, exp_pass(f, c[3:0]));
        end
      end
    end
    // Hand-computed spot checks for NZCV=0110
    do_msr(1'b0, 4'b1000, 32'h6000_0000);
    cond = 4'h0; #1; checks++;
    if (cond_pass !== 1'b1) begin errors++; $display("FAIL spot_EQ got %b exp 1", cond_pass); end
    cond = 4'h8; #1; checks++;
    if (cond_pass !== 1'b0) begin errors++; $display("FAIL spot_HI got %b exp 0", cond_pass); end
    cond = 4'h9; #1; checks++;
    if (cond_pass !== 1'b1) begin errors++; $display("FAIL spot_LS got %b exp 1", cond_pass); end
    cond = 4'ha; #1; checks++;
    if (cond_pass !== 1'b1) begin errors++; $display("FAIL spot_GE got %b exp 1", cond_pass); end
    cond = 4'hc; #1; checks++;
    if (cond_pass !== 1'b0) begin errors++; $display("FAIL spot_GT got %b exp 0", cond_pass); end
    cond = 4'hd; #1; checks++;
    if (cond_pass !== 1'b1) begin errors++; $display("FAIL spot_LE got %b exp 1", cond_pass); end
    cond = 4'hf; #1; checks++;
    if (cond_pass !== 1'b0) begin errors++; $display("FAIL spot_NV got %b exp 0", cond_pass); end
    checks++;
    if ({CF, VF} !== 2'b10) begin errors++; $display("FAIL spot_CFVF got %b exp 10", {CF, VF}); end
    idle();
  endtask

  task automatic test_flag_gating();
    do_msr(1'b0, 4'b1000, 32'h0000_0000);
    exec_valid = 1'b1; cond = 4'h0; s_bit = 1'b1; alu_nzcv = 4'hF;
    tick(); idle();
    checks++;
    if (cpsr[31:28] !== 4'h0) begin
      errors++; $display("FAIL gate_eq_fail got %h exp %h", cpsr[31:28], 4'h0);
    end
    do_msr(1'b0, 4'b1000, 32'h4000_0000);
    exec_valid = 1'b1; cond = 4'h0; s_bit = 1'b1; alu_nzcv = 4'hF;
    tick(); idle();
    checks++;
    if (cpsr !== 32'hF00000D3) begin
      errors++; $display("FAIL gate_eq_pass got %h exp %h", cpsr, 32'hF00000D3);
    end
    checks++;
    if ({CF, VF} !== 2'b11) begin
      errors++; $display("FAIL gate_cfvf got %b exp 11", {CF, VF});
    end
    exec_valid = 1'b0; cond = 4'he; s_bit = 1'b1; alu_nzcv = 4'h0;
    tick(); idle();
    checks++;
    if (cpsr[31:28] !== 4'hF) begin
      errors++; $display("FAIL gate_novalid got %h exp %h", cpsr[31:28], 4'hF);
    end
    exec_valid = 1'b1; cond = 4'he; s_bit = 1'b0; alu_nzcv = 4'h0;
    tick(); idle();
    checks++;
    if (cpsr[31:28] !== 4'hF) begin
      errors++; $display("FAIL gate_nos got %h exp %h", cpsr[31:28], 4'hF);
    end
  endtask

  task automatic test_back_to_back();
    // flags F -> clear via AL, then EQ must see Z=0 in the very next cycle
    exec_valid = 1'b1; s_bit = 1'b1; cond = 4'he; alu_nzcv = 4'h0;
    tick();
    cond = 4'h0; alu_nzcv = 4'hA;
    #1; checks++;
    if (cond_pass !== 1'b0) begin errors++; $display("FAIL b2b_eq_pass got %b exp 0", cond_pass); end
    tick();
    checks++;
    if (cpsr[31:28] !== 4'h0) begin errors++; $display("FAIL b2b_eq_flags got %h exp 0", cpsr[31:28]); end
    cond = 4'h1; alu_nzcv = 4'h5;
    tick();
    cond = 4'h6; alu_nzcv = 4'h8;
    #1; checks++;
    if (cond_pass !== 1'b1) begin errors++; $display("FAIL b2b_vs_pass got %b exp 1", cond_pass); end
    tick(); idle();
    checks++;
    if (cpsr !== 32'h800000D3) begin errors++; $display("FAIL b2b_final got %h exp %h", cpsr, 32'h800000D3); end
  endtask

  task automatic test_msr_spsr();
    do_msr(1'b1, 4'b1001, 32'h9000_00F1);
    mrs_spsr = 1'b1; #1;
    checks++;
    if (psr_rdata !== 32'h900000D1) begin
      errors++; $display("FAIL msr_spsr got %h exp %h", psr_rdata, 32'h900000D1);
    end
    mrs_spsr = 1'b0;
  endtask

  task automatic test_user_mode();
    do_msr(1'b0, 4'b1001, 32'hA000_0010);
    checks++;
    if (cpsr !== 32'hA0000010) begin
      errors++; $display("FAIL user_enter got %h exp %h", cpsr, 32'hA0000010);
    end
    do_msr(1'b0, 4'b0001, 32'h0000_00D3);
    checks++;
    if (cpsr !== 32'hA0000010) begin
      errors++; $display("FAIL user_ctrl_locked got %h exp %h", cpsr, 32'hA0000010);
    end
    do_msr(1'b0, 4'b1000, 32'h6000_0000);
    checks++;
    if (cpsr !== 32'h60000010) begin
      errors++; $display("FAIL user_flags got %h exp %h", cpsr, 32'h60000010);
    end
  endtask

  task automatic test_exception();
    exc_entry = 1'b1; exc_mode = 5'b10010;
    tick(); idle();
    checks++;
    if (cpsr !== 32'h60000092) begin
      errors++; $display("FAIL exc_entry_cpsr got %h exp %h", cpsr, 32'h60000092);
    end
    mrs_spsr = 1'b1; #1;
    checks++;
    if (psr_rdata !== 32'h60000010) begin
      errors++; $display("FAIL exc_entry_spsr got %h exp %h", psr_rdata, 32'h60000010);
    end
    mrs_spsr = 1'b0;
    exc_return = 1'b1;
    tick(); idle();
    checks++;
    if (cpsr !== 32'h60000010) begin
      errors++; $display("FAIL exc_return got %h exp %h", cpsr, 32'h60000010);
    end
    exc_entry = 1'b1; exc_mode = 5'b10011;
    tick(); idle();
    do_msr(1'b0, 4'b0001, 32'h0000_00C5);
    checks++;
    if (cpsr !== 32'h600000D3) begin
      errors++; $display("FAIL bad_mode got %h exp %h", cpsr, 32'h600000D3);
    end
  endtask

  task automatic test_simultaneous();
    exc_entry = 1'b1; exc_mode = 5'b10111;
    msr_we = 1'b1; msr_spsr = 1'b0; msr_mask = 4'b1000; msr_data = 32'hF000_0000;
    exec_valid = 1'b1; cond = 4'he; s_bit = 1'b1; alu_nzcv = 4'hF;
    tick(); idle();
    checks++;
    if (cpsr !== 32'h600000D7) begin
      errors++; $display("FAIL sim_entry_cpsr got %h exp %h", cpsr, 32'h600000D7);
    end
    mrs_spsr = 1'b1; #1;
    checks++;
    if (psr_rdata !== 32'h600000D3) begin
      errors++; $display("FAIL sim_entry_spsr got %h exp %h", psr_rdata, 32'h600000D3);
    end
    mrs_spsr = 1'b0;
    exc_return = 1'b1;
    msr_we = 1'b1; msr_spsr = 1'b0; msr_mask = 4'b1000; msr_data = 32'h0;
    tick(); idle();
    checks++;
    if (cpsr !== 32'h600000D3) begin
      errors++; $display("FAIL sim_return got %h exp %h", cpsr, 32'h600000D3);
    end
    exc_entry = 1'b1; exc_mode = 5'b11011;
    msr_we = 1'b1; msr_spsr = 1'b1; msr_mask = 4'b1001; msr_data = 32'h0;
    tick(); idle();
    mrs_spsr = 1'b1; #1;
    checks++;
    if (psr_rdata !== 32'h600000D3) begin
      errors++; $display("FAIL sim_spsr_drop got %h exp %h", psr_rdata, 32'h600000D3);
    end
    mrs_spsr = 1'b0; #1;
    checks++;
    if (cpsr !== 32'h600000DB) begin
      errors++; $display("FAIL sim_spsr_cpsr got %h exp %h", cpsr, 32'h600000DB);
    end
  endtask

  task automatic test_reset_mid();
    exc_entry = 1'b1; exc_mode = 5'b10001;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cpsr !== 32'h000000D3) begin
      errors++; $display("FAIL mid_reset_cpsr got %h exp %h", cpsr, 32'h000000D3);
    end
    mrs_spsr = 1'b1; #1;
    checks++;
    if (psr_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_reset_spsr got %h exp %h", psr_rdata, 32'h0);
    end
    mrs_spsr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); idle();
    checks++;
    if (cpsr !== 32'h000000D1) begin
      errors++; $display("FAIL post_reset_entry got %h exp %h", cpsr, 32'h000000D1);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    mrs_spsr = 1'b0;
    idle();
    #3;
    test_reset();
    test_cond_sweep();
    test_flag_gating();
    test_back_to_back();
    test_msr_spsr();
    test_user_mode();
    test_exception();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
